// File: rtl/pwm_counter_if.sv
// Bundle of control inputs and timebase outputs for the PWM counter.
// Purely combinational wiring; no latency of its own.
// No backpressure: the counter consumes controls every cycle and outputs are always valid.
interface pwm_counter_if #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
);
  logic               en;
  logic               count_reset;
  logic               upnotdown;
  logic [WIDTH-1:0]   period;
  logic [PRESC_W-1:0] prescale;
  logic [WIDTH-1:0]   count_val;
  logic               period_done;

  // Register-block side: drives controls, observes the timebase
  modport master (
    output en, count_reset, upnotdown, period, prescale,
    input  count_val, period_done
  );

  // Counter side: consumes controls, produces the timebase
  modport slave (
    input  en, count_reset, upnotdown, period, prescale,
    output count_val, period_done
  );
endinterface

// File: rtl/pwm_counter.sv
// Prescaled up/down timebase with shadowed period/prescale that reload only at wrap.
// Latency: one clk from tick condition to updated count_val / period_done.
// No backpressure: free-running whenever en=1, frozen when en=0.
module pwm_counter #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  pwm_counter_if.slave bus
);

  localparam logic [WIDTH-1:0]   ONE_CNT = WIDTH'(1);
  localparam logic [PRESC_W-1:0] ONE_PC  = PRESC_W'(1);

  logic [WIDTH-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [WIDTH-1:0]   act_period_q, act_period_d;
  logic [PRESC_W-1:0] act_presc_q, act_presc_d;
  logic               done_q, done_d;
  logic               tick;
  logic               wrap;

  // Next-state: clear beats run logic; shadows follow inputs when stopped or at a wrap
  always_comb begin
    count_d      = count_q;
    presc_cnt_d  = presc_cnt_q;
    act_period_d = act_period_q;
    act_presc_d  = act_presc_q;
    done_d       = 1'b0;
    tick         = 1'b0;
    wrap         = 1'b0;

    if (bus.count_reset) begin
      count_d      = '0;
      presc_cnt_d  = '0;
      act_period_d = bus.period;
      act_presc_d  = bus.prescale;
    end else if (!bus.en) begin
      act_period_d = bus.period;
      act_presc_d  = bus.prescale;
    end else begin
      tick        = (presc_cnt_q == act_presc_q);
      presc_cnt_d = tick ? '0 : presc_cnt_q + ONE_PC;
      if (tick) begin
        if (bus.upnotdown) begin
          // >= also catches a count stranded above a period shrunk while stopped
          if (count_q >= act_period_q) begin
            count_d = '0;
            wrap    = 1'b1;
          end else begin
            count_d = count_q + ONE_CNT;
          end
        end else begin
          // Down-count reloads from the live input, which is also the next shadow
          if (count_q == '0) begin
            count_d = bus.period;
            wrap    = 1'b1;
          end else begin
            count_d = count_q - ONE_CNT;
          end
        end
      end
      if (wrap) begin
        done_d       = 1'b1;
        act_period_d = bus.period;
        act_presc_d  = bus.prescale;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q      <= '0;
      presc_cnt_q  <= '0;
      act_period_q <= '0;
      act_presc_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      presc_cnt_q  <= presc_cnt_d;
      act_period_q <= act_period_d;
      act_presc_q  <= act_presc_d;
      done_q       <= done_d;
    end
  end

  assign bus.count_val   = count_q;
  assign bus.period_done = done_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Self-checking bench: table of per-cycle vectors plus a prescale-max sequence.
// Expected values are queued at drive time and popped after each posedge.
// Inputs driven on negedge, outputs sampled 1 time unit after posedge.
module tb_pwm_counter;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        up;
    logic [15:0] per;
    logic [7:0]  presc;
    logic [15:0] exp_cnt;
    logic        exp_done;
  } vec_t;

  typedef struct {
    logic [15:0] cnt;
    logic        done;
    int          idx;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  vec_t vecs[$];
  exp_t exp_q[$];

  pwm_counter_if #(.WIDTH(16), .PRESC_W(8)) bus ();

  pwm_counter #(.WIDTH(16), .PRESC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic e, input logic c, input logic u,
                             input logic [15:0] p, input logic [7:0] ps,
                             input logic [15:0] ec, input logic ed);
    vec_t t;
    t.rst_n = r; t.en = e; t.clr = c; t.up = u; t.per = p; t.presc = ps;
    t.exp_cnt = ec; t.exp_done = ed;
    return t;
  endfunction

  task automatic step(input vec_t t, input int idx);
    exp_t x;
    exp_t got;
    @(negedge clk);
    rst_n           = t.rst_n;
    bus.en          = t.en;
    bus.count_reset = t.clr;
    bus.upnotdown   = t.up;
    bus.period      = t.per;
    bus.prescale    = t.presc;
    x.cnt  = t.exp_cnt;
    x.done = t.exp_done;
    x.idx  = idx;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    checks++;
    if (bus.count_val !== got.cnt) begin
      errors++;
      $display("FAIL count_val step %0d: got %0d expected %0d", got.idx, bus.count_val, got.cnt);
    end
    checks++;
    if (bus.period_done !== got.done) begin
      errors++;
      $display("FAIL period_done step %0d: got %0b expected %0b", got.idx, bus.period_done, got.done);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.count_reset = 1'b0; bus.upnotdown = 1'b1;
    bus.period = '0; bus.prescale = '0;

    //                 rst en clr up per presc  cnt done
    // reset, load shadows, up-count period 3
    vecs.push_back(v(0, 0, 0, 1, 3, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 3, 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 1, 3, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 0, 2, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 0, 3, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 0, 0, 1));
    vecs.push_back(v(1, 1, 0, 1, 3, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 0, 2, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 0, 3, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 0, 0, 1));
    // prescale 2: each value held 3 clk
    vecs.push_back(v(1, 1, 1, 1, 3, 2, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 2, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 2, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 2, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 3, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 3, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 3, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 0, 1));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 2, 1, 0));
    // down-count from reset
    vecs.push_back(v(0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 0, 3, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 3, 0, 3, 1));
    vecs.push_back(v(1, 1, 0, 0, 3, 0, 2, 0));
    vecs.push_back(v(1, 1, 0, 0, 3, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 3, 0, 3, 1));
    vecs.push_back(v(1, 1, 0, 0, 3, 0, 2, 0));
    // period 3 -> 5 written at count 1: current period still ends at 3
    vecs.push_back(v(1, 0, 1, 1, 3, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 3, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 2, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 3, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 0, 1));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 2, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 3, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 4, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 5, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 0, 1));
    // direction flip mid-period: no reload, no pulse
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 2, 0));
    vecs.push_back(v(1, 1, 0, 0, 5, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 2, 0));
    // clear with a tick due
    vecs.push_back(v(1, 1, 1, 1, 5, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 1, 0));
    // clear also zeroes the prescaler count
    vecs.push_back(v(1, 1, 1, 1, 5, 2, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 2, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 2, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 2, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 2, 1, 0));
    vecs.push_back(v(1, 1, 1, 1, 5, 2, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 2, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 2, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 2, 1, 0));
    // freeze at 2 for 5 clk, then resume
    vecs.push_back(v(1, 0, 1, 1, 5, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 2, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(v(1, 0, 0, 1, 5, 0, 2, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 3, 0));
    // clear coincident with a wrap
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 4, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 5, 0));
    vecs.push_back(v(1, 1, 1, 1, 5, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 1, 0));
    // period 0: wrap every tick
    vecs.push_back(v(1, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(v(1, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(v(1, 1, 0, 1, 0, 0, 0, 1));
    // period shrunk below count while stopped
    vecs.push_back(v(1, 0, 1, 1, 5, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 2, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 3, 0));
    vecs.push_back(v(1, 1, 0, 1, 5, 0, 4, 0));
    vecs.push_back(v(1, 0, 0, 1, 2, 0, 4, 0));
    vecs.push_back(v(1, 1, 0, 1, 2, 0, 0, 1));
    vecs.push_back(v(1, 1, 0, 1, 2, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 2, 0, 2, 0));
    vecs.push_back(v(1, 1, 0, 1, 2, 0, 0, 1));
    // reset mid-count clears shadows too: first tick wraps at period 0
    vecs.push_back(v(0, 1, 0, 1, 2, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 2, 0, 0, 1));
    vecs.push_back(v(1, 1, 0, 1, 2, 0, 1, 0));
    // down wrap reloads from the live period input
    vecs.push_back(v(1, 1, 0, 0, 4, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 4, 0, 4, 1));
    vecs.push_back(v(1, 1, 0, 0, 4, 0, 3, 0));

    foreach (vecs[i]) step(vecs[i], i);

    // prescale at max: one tick per 256 clk, two full prescaler rounds
    step(v(1, 0, 1, 1, 3, 8'hFF, 0, 0), 1000);
    for (int k = 1; k <= 512; k++) begin
      step(v(1, 1, 0, 1, 3, 8'hFF, (k >= 512) ? 16'd2 : (k >= 256) ? 16'd1 : 16'd0, 0), 1000 + k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
